// File: rtl/demux_1x8_buf_if.sv
// Bundle of the producer handshake, per-slot consumer signals and status of demux_1x8_buf.
// master = producer/consumer side, slave = the distributor itself.
interface demux_1x8_buf_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             clear;
    logic             auto_mode;
    logic [2:0]       Sel;
    logic [WIDTH-1:0] In;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Out1;
    logic [WIDTH-1:0] Out2;
    logic [WIDTH-1:0] Out3;
    logic [WIDTH-1:0] Out4;
    logic [WIDTH-1:0] Out5;
    logic [WIDTH-1:0] Out6;
    logic [WIDTH-1:0] Out7;
    logic [WIDTH-1:0] Out8;
    logic [7:0]       out_valid;
    logic [7:0]       out_ack;
    logic [2:0]       wr_ptr;
    logic [3:0]       fill_count;
    logic             overflow;

    modport master (
        output enable, clear, auto_mode, Sel, In, in_valid, out_ack,
        input  in_ready, Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8,
        input  out_valid, wr_ptr, fill_count, overflow
    );

    modport slave (
        input  enable, clear, auto_mode, Sel, In, in_valid, out_ack,
        output in_ready, Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8,
        output out_valid, wr_ptr, fill_count, overflow
    );
endinterface

// File: rtl/demux_1x8_buf.sv
// One-to-eight distributor: each accepted word lands in one of eight holding registers with a valid flag.
// Optional macro DEMUX_OVERWRITE_EN: writes to occupied slots overwrite and pulse overflow.
module demux_1x8_buf #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    demux_1x8_buf_if.slave bus
);
    localparam int SLOTS = 8;

    logic [WIDTH-1:0] data_q [SLOTS];
    logic [WIDTH-1:0] data_d [SLOTS];
    logic [7:0]       out_valid_q, out_valid_d;
    logic [2:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]       fill_count_q, fill_count_d;

    logic [2:0]       tgt;
    logic             slot_busy;
    logic [7:0]       ack_hit;
    logic             in_ready_c;
    logic             accept;

    // A same-cycle ack on the target frees it, so only "valid and not acked" is busy.
    always_comb begin
        tgt       = bus.auto_mode ? wr_ptr_q : bus.Sel;
        slot_busy = out_valid_q[tgt] & ~bus.out_ack[tgt];
        ack_hit   = bus.out_ack & out_valid_q;
`ifdef DEMUX_OVERWRITE_EN
        in_ready_c = bus.enable & ~bus.clear;
`else
        in_ready_c = bus.enable & ~bus.clear & ~slot_busy;
`endif
        accept    = bus.in_valid & in_ready_c;
    end

    // NOTE: every always_comb output gets a default first; otherwise a missed branch infers a latch.
    always_comb begin
        data_d      = data_q;
        out_valid_d = out_valid_q;
        wr_ptr_d    = wr_ptr_q;
        if (bus.clear) begin
            out_valid_d = '0;
            wr_ptr_d    = '0;
        end else begin
            out_valid_d = out_valid_q & ~ack_hit;
            if (accept) begin
                data_d[tgt]      = bus.In;
                out_valid_d[tgt] = 1'b1;
                if (bus.auto_mode) begin
                    wr_ptr_d = wr_ptr_q + 3'd1;
                end
            end
        end
    end

    // NOTE: blocking '=' accumulates within one evaluation here; flops below use only '<='.
    always_comb begin
        fill_count_d = '0;
        for (int i = 0; i < SLOTS; i++) begin
            fill_count_d = fill_count_d + {3'b000, out_valid_d[i]};
        end
    end

    // NOTE: the holding registers are visible outputs that must read 0 after reset, so this
    // small array is reset explicitly rather than left uninitialised like a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                data_q[i] <= '0;
            end
            out_valid_q  <= '0;
            wr_ptr_q     <= '0;
            fill_count_q <= '0;
        end else begin
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_count_q <= fill_count_d;
        end
    end

`ifdef DEMUX_OVERWRITE_EN
    logic overflow_q, overflow_d;

    // Overwrite means the accepted write hit a slot that was still holding unconsumed data.
    always_comb begin
        overflow_d = ~bus.clear & accept & slot_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.fill_count = fill_count_q;
    assign bus.Out1       = data_q[0];
    assign bus.Out2       = data_q[1];
    assign bus.Out3       = data_q[2];
    assign bus.Out4       = data_q[3];
    assign bus.Out5       = data_q[4];
    assign bus.Out6       = data_q[5];
    assign bus.Out7       = data_q[6];
    assign bus.Out8       = data_q[7];

endmodule

// File: tb/tb_demux_1x8_buf.sv
// Table-driven directed bench for demux_1x8_buf; expectations follow DEMUX_OVERWRITE_EN when defined.
module tb_demux_1x8_buf;

`ifdef DEMUX_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1x8_buf_if #(.WIDTH(8)) bus ();

    demux_1x8_buf #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       am;
        logic [2:0] sel;
        logic [7:0] din;
        logic       iv;
        logic [7:0] ack;
        logic       e_rdy;
        logic [7:0] e_valid;
        logic [3:0] e_fill;
        logic [2:0] e_ptr;
        logic       e_ovf;
        int         slot;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] out_at(input int i);
        case (i)
            0: return bus.Out1;
            1: return bus.Out2;
            2: return bus.Out3;
            3: return bus.Out4;
            4: return bus.Out5;
            5: return bus.Out6;
            6: return bus.Out7;
            default: return bus.Out8;
        endcase
    endfunction

    function automatic vec_t mk(input int en, input int clr, input int am, input int sel,
                                input int din, input int iv, input int ack, input int rdy,
                                input int vld, input int fill, input int ptr, input int ovf,
                                input int slot, input int data);
        vec_t v;
        v.en = 1'(en);  v.clr = 1'(clr); v.am = 1'(am); v.sel = 3'(sel);
        v.din = 8'(din); v.iv = 1'(iv);  v.ack = 8'(ack);
        v.e_rdy = 1'(rdy); v.e_valid = 8'(vld); v.e_fill = 4'(fill);
        v.e_ptr = 3'(ptr); v.e_ovf = 1'(ovf); v.slot = slot; v.e_data = 8'(data);
        return v;
    endfunction

    initial begin
        int ptr_b;
        ptr_b = OVW ? 3 : 2;
        //           en clr am sel din   iv ack    rdy  valid fill ptr  ovf slot data
        vecs.push_back(mk(1, 0, 0, 3, 'hA5, 1, 'h00, 1,   'h08, 1, 0,     0,  3, 'hA5));
        vecs.push_back(mk(1, 0, 0, 0, 'h00, 0, 'h00, 1,   'h08, 1, 0,     0,  0, 'h00));
        vecs.push_back(mk(1, 0, 0, 3, 'h00, 0, 'h08, 1,   'h00, 0, 0,     0,  3, 'hA5));
        vecs.push_back(mk(1, 0, 1, 0, 'h10, 1, 'h00, 1,   'h01, 1, 1,     0,  0, 'h10));
        vecs.push_back(mk(1, 0, 1, 0, 'h11, 1, 'h01, 1,   'h02, 1, 2,     0,  1, 'h11));
        vecs.push_back(mk(1, 0, 1, 0, 'h12, 1, 'h00, 1,   'h06, 2, 3,     0,  2, 'h12));
        vecs.push_back(mk(1, 0, 1, 0, 'h13, 1, 'h00, 1,   'h0E, 3, 4,     0,  3, 'h13));
        vecs.push_back(mk(1, 0, 1, 0, 'h14, 1, 'h00, 1,   'h1E, 4, 5,     0,  4, 'h14));
        vecs.push_back(mk(1, 0, 1, 0, 'h15, 1, 'h00, 1,   'h3E, 5, 6,     0,  5, 'h15));
        vecs.push_back(mk(1, 0, 1, 0, 'h16, 1, 'h00, 1,   'h7E, 6, 7,     0,  6, 'h16));
        vecs.push_back(mk(1, 0, 1, 0, 'h17, 1, 'h00, 1,   'hFE, 7, 0,     0,  7, 'h17));
        vecs.push_back(mk(1, 0, 1, 0, 'h18, 1, 'h00, 1,   'hFF, 8, 1,     0,  0, 'h18));
        // Full: ack on the pointed slot lets a same-cycle write through.
        vecs.push_back(mk(1, 0, 1, 0, 'h20, 1, 'h02, 1,   'hFF, 8, 2,     0,  1, 'h20));
        // Full, no ack: blocked, or overwritten when the feature is built in.
        vecs.push_back(mk(1, 0, 1, 0, 'h99, 1, 'h00, OVW, 'hFF, 8, ptr_b, OVW, 2, OVW ? 'h99 : 'h12));
        vecs.push_back(mk(1, 0, 1, 0, 'h00, 0, 'h00, OVW, 'hFF, 8, ptr_b, 0,  2, OVW ? 'h99 : 'h12));
        // enable low: no write, acks still honoured, data kept.
        vecs.push_back(mk(0, 0, 0, 0, 'h77, 1, 'h00, 0,   'hFF, 8, ptr_b, 0,  0, 'h18));
        vecs.push_back(mk(0, 0, 0, 0, 'h00, 0, 'h0F, 0,   'hF0, 4, ptr_b, 0,  0, 'h18));
        vecs.push_back(mk(1, 0, 0, 0, 'h00, 0, 'h01, 1,   'hF0, 4, ptr_b, 0,  0, 'h18));
        vecs.push_back(mk(1, 0, 0, 0, 'h00, 0, 'hF0, 1,   'h00, 0, ptr_b, 0,  4, 'h14));
        vecs.push_back(mk(1, 0, 0, 2, 'h33, 1, 'h00, 1,   'h04, 1, ptr_b, 0,  2, 'h33));
        vecs.push_back(mk(1, 0, 0, 5, 'h66, 1, 'h00, 1,   'h24, 2, ptr_b, 0,  5, 'h66));
        // clear beats the write and the ack in the same cycle.
        vecs.push_back(mk(1, 1, 0, 0, 'hEE, 1, 'h04, 0,   'h00, 0, 0,     0,  2, 'h33));
        vecs.push_back(mk(1, 0, 0, 0, 'h00, 0, 'h00, 1,   'h00, 0, 0,     0,  5, 'h66));
        vecs.push_back(mk(1, 0, 0, 1, 'h11, 1, 'h00, 1,   'h02, 1, 0,     0,  1, 'h11));
        vecs.push_back(mk(1, 0, 0, 1, 'h22, 1, 'h00, OVW, 'h02, 1, 0,     OVW, 1, OVW ? 'h22 : 'h11));
        vecs.push_back(mk(1, 0, 0, 4, 'h44, 1, 'h00, 1,   'h12, 2, 0,     0,  4, 'h44));
        vecs.push_back(mk(1, 0, 0, 1, 'h55, 1, 'h02, 1,   'h12, 2, 0,     0,  1, 'h55));
        vecs.push_back(mk(1, 0, 0, 0, 'h00, 0, 'h90, 1,   'h02, 1, 0,     0,  4, 'h44));
        vecs.push_back(mk(1, 0, 1, 0, 'hA0, 1, 'h00, 1,   'h03, 2, 1,     0,  0, 'hA0));
        vecs.push_back(mk(1, 0, 0, 6, 'hB6, 1, 'h00, 1,   'h43, 3, 1,     0,  6, 'hB6));
        vecs.push_back(mk(1, 0, 1, 0, 'hA1, 1, 'h02, 1,   'h43, 3, 2,     0,  1, 'hA1));

        bus.enable = 1'b0; bus.clear = 1'b0; bus.auto_mode = 1'b0; bus.Sel = 3'd0;
        bus.In = 8'h00; bus.in_valid = 1'b0; bus.out_ack = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", bus.out_valid, 8'h00);
        check("rst.fill", bus.fill_count, 4'd0);
        check("rst.ptr", bus.wr_ptr, 3'd0);
        check("rst.ovf", bus.overflow, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("rst.out%0d", i + 1), out_at(i), 8'h00);
        rst = 1'b0;

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            @(negedge clk);
            bus.enable = v.en; bus.clear = v.clr; bus.auto_mode = v.am; bus.Sel = v.sel;
            bus.In = v.din; bus.in_valid = v.iv; bus.out_ack = v.ack;
            #1;
            check($sformatf("v%0d.in_ready", k), bus.in_ready, v.e_rdy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.out_valid", k), bus.out_valid, v.e_valid);
            check($sformatf("v%0d.fill", k), bus.fill_count, v.e_fill);
            check($sformatf("v%0d.ptr", k), bus.wr_ptr, v.e_ptr);
            check($sformatf("v%0d.ovf", k), bus.overflow, v.e_ovf);
            check($sformatf("v%0d.out%0d", k, v.slot + 1), out_at(v.slot), v.e_data);
        end

        // Mid-stream reset wins over a pending write.
        @(negedge clk);
        rst = 1'b1;
        bus.enable = 1'b1; bus.clear = 1'b0; bus.auto_mode = 1'b1; bus.In = 8'hFF;
        bus.in_valid = 1'b1; bus.out_ack = 8'h00;
        @(posedge clk);
        #1;
        check("rst2.out_valid", bus.out_valid, 8'h00);
        check("rst2.fill", bus.fill_count, 4'd0);
        check("rst2.ptr", bus.wr_ptr, 3'd0);
        check("rst2.ovf", bus.overflow, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("rst2.out%0d", i + 1), out_at(i), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x8_buf.md
Name: demux_1x8_buf

Overview:
- One-to-eight distributor: the write-side counterpart of the 8:1 selector.
- Accepts one WIDTH-bit word per handshake and stores it in one of eight holding registers. The register is chosen by Sel, or by an internal round-robin pointer in auto mode.
- Each holding register has its own valid flag, cleared by its consumer's ack. The block sits between a single producer (keypad/scanner byte stream) and the eight per-slot consumers that feed the terminal's selector.

Parameters:
- WIDTH, 8, data width of the input word and of each holding register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low blocks new writes.
- clear  input  1  synchronous flush: drops all valid flags, resets pointer.
- auto_mode  input  1  1 = target is the internal pointer; 0 = target is Sel.
- Sel  input  3  slot select when auto_mode=0.
- In  input  WIDTH  input word.
- in_valid  input  1  producer has a word on In.
- in_ready  output  1  block accepts In this cycle.
- Out1..Out8  output  WIDTH each  holding registers, slot 0..7.
- out_valid  output  8  bit i = slot i holds unconsumed data.
- out_ack  input  8  bit i = consumer i takes slot i this cycle.
- wr_ptr  output  3  current auto-mode pointer.
- fill_count  output  4  number of set out_valid bits, 0..8.
- overflow  output  1  one-cycle pulse on an overwrite (feature only).

Behaviour:
- Reset (rst=1 at edge): Out1..Out8=0, out_valid=0, wr_ptr=0, fill_count=0, overflow=0. rst has priority over every other input.
- clear=1 (rst=0): out_valid=0, wr_ptr=0, fill_count=0 next cycle. Out registers hold their values. Writes and acks in the same cycle are ignored.
- Target slot t = auto_mode ? wr_ptr : Sel. Combinational only.
- in_ready = enable & ~clear & (~out_valid[t] | out_ack[t]). Combinational; a same-cycle ack frees the slot.
- Write when in_valid & in_ready:
  - Out[t] <= In and out_valid[t] <= 1 at the next edge. Latency is 1 cycle from accept to out_valid.
  - If auto_mode=1, wr_ptr <= wr_ptr+1 mod 8, wrapping from 7 to 0.
  - If auto_mode=0, wr_ptr holds.
- Ack: out_ack[i] & out_valid[i] clears out_valid[i] next cycle. An ack on an invalid slot is ignored. Out[i] keeps its value after an ack.
- Simultaneous ack and write on the same slot: out_valid[t] stays 1 and Out[t] takes the new word.
- Multiple acks in one cycle: all are honoured.
- enable=0: no writes and no pointer movement. Acks are still processed. Registers are not zeroed.
- Toggling auto_mode mid-stream: wr_ptr is retained and resumes from its current value.
- Full condition: all 8 valid with no ack. In auto mode this gives in_ready=0. In Sel mode, in_ready=0 only when the selected slot is full.
- fill_count is registered and always equals popcount(out_valid). Its update per cycle is +writes to empty slots, −acked slots.
- in_valid held with in_ready=0: In must be held stable by the producer. The block samples only on accept.

Optional Feature:
- Macro: DEMUX_OVERWRITE_EN.
- Defined:
  - in_ready = enable & ~clear, regardless of slot state.
  - A write to a valid, un-acked slot replaces Out[t] and keeps out_valid[t]=1.
  - overflow pulses 1 for exactly one cycle, the cycle after that write.
  - fill_count is unchanged on an overwrite.
- Undefined:
  - overflow is tied to 0.
  - in_ready follows the backpressure rule in Behaviour.

Test Plan:
- Reset then Sel mode: rst=1 one cycle, then Sel=3, In=8'hA5, in_valid=1 for one cycle → next cycle Out4=8'hA5, out_valid=8'b0000_1000, fill_count=1, others 0.
- Auto-mode wrap: auto_mode=1, write 9 words 8'h10..8'h18 with slot 0 acked after the first write → Out1..Out8=10..17, then Out1=18. wr_ptr sequence 0..7,0,1; in_ready never drops.
- Backpressure: auto_mode=1, fill all 8 with no acks → in_ready=0, fill_count=8. Pulse out_ack[0] with in_valid=1 → same-cycle accept; Out1 takes new word, out_valid[0] stays 1, fill_count stays 8.
- Enable and clear: enable=0 with in_valid=1 → no change, in_ready=0. Pulse clear with slots 2,5 valid → out_valid=0, wr_ptr=0, Out3/Out6 values retained.
- Multiple acks: slots 0..3 valid, out_ack=8'h0F → next cycle out_valid=0, fill_count=0. out_ack on an empty slot → no change.
- DEMUX_OVERWRITE_EN build: slot 1 valid with 8'h11, write Sel=1, In=8'h22 → Out2=8'h22, overflow=1 for one cycle, fill_count unchanged. Without the macro, the same stimulus gives in_ready=0 and Out2 stays 8'h11.
